// File: rtl/gsu_mmio_wr_pkg.sv
// Shared GSU definitions: MMIO register offsets (relative to $3000), SFR bit positions,
// cache geometry and the write-decode classification used by the MMIO write path.
package gsu_mmio_wr_pkg;

    localparam int unsigned GSU_CACHE_LINES = 32;
    localparam int unsigned SFR_G_BIT       = 5;

    localparam logic [9:0] OFS_R0      = 10'h000;
    localparam logic [9:0] OFS_R15H    = 10'h01F;
    localparam logic [9:0] OFS_SFR_LO  = 10'h030;
    localparam logic [9:0] OFS_SFR_HI  = 10'h031;
    localparam logic [9:0] OFS_BRAMR   = 10'h033;
    localparam logic [9:0] OFS_PBR     = 10'h034;
    localparam logic [9:0] OFS_CFGR    = 10'h037;
    localparam logic [9:0] OFS_SCBR    = 10'h038;
    localparam logic [9:0] OFS_CLSR    = 10'h039;
    localparam logic [9:0] OFS_SCMR    = 10'h03A;
    localparam logic [9:0] OFS_CACHE   = 10'h100;
    localparam logic [9:0] OFS_END     = 10'h300;

    typedef enum logic [3:0] {
        WK_NONE,
        WK_REG_LO,
        WK_REG_HI,
        WK_SFR,
        WK_BRAMR,
        WK_PBR,
        WK_CFGR,
        WK_SCBR,
        WK_CLSR,
        WK_SCMR,
        WK_CACHE
    } wr_kind_t;

endpackage

// File: rtl/gsu_mmio_wr_if.sv
// SNES-side write bus seen by the GSU MMIO write decoder.
interface gsu_mmio_wr_if;

    logic [23:0] ADDR;
    logic [7:0]  DI;
    logic        CS;
    logic        reg_we_rising;

    modport master (output ADDR, DI, CS, reg_we_rising);
    modport slave  (input  ADDR, DI, CS, reg_we_rising);

endinterface

// File: rtl/gsu_mmio_wr.sv
// GSU MMIO write path: register-file commits, SFR go control, single-byte config
// registers and instruction-cache fills, all registered one cycle after the bus strobe.
module gsu_mmio_wr
    import gsu_mmio_wr_pkg::*;
#(
    parameter int unsigned CACHE_LINES = GSU_CACHE_LINES
) (
    input  logic                   clkin,
    input  logic                   rst,
    gsu_mmio_wr_if.slave           bus,
    input  logic                   core_stop,
    output logic                   reg_we,
    output logic [3:0]             reg_idx,
    output logic [15:0]            reg_data,
    output logic                   go,
    output logic                   go_start,
    output logic [7:0]             pbr,
    output logic [7:0]             scbr,
    output logic [7:0]             cfgr,
    output logic [5:0]             scmr,
    output logic                   bramr,
    output logic                   clsr,
    output logic                   cache_we,
    output logic [8:0]             cache_addr,
    output logic [7:0]             cache_din,
    output logic [CACHE_LINES-1:0] cache_valid
);

    // Classifies an accepted write; anything outside $3000-$32FF or unstrobed is WK_NONE.
    function automatic wr_kind_t decode_wr(input logic cs, input logic strobe,
                                           input logic [23:0] a);
        logic [9:0] o;
        o = a[9:0];
        if (!(cs && strobe && !a[22] && a[15:12] == 4'h3 && a[11:0] < {2'b00, OFS_END}))
            return WK_NONE;
        if (o <= OFS_R15H)
            return o[0] ? WK_REG_HI : WK_REG_LO;
        if (o >= OFS_CACHE)
            return WK_CACHE;
        case (o)
            OFS_SFR_HI: return WK_SFR;
            OFS_BRAMR:  return WK_BRAMR;
            OFS_PBR:    return WK_PBR;
            OFS_CFGR:   return WK_CFGR;
            OFS_SCBR:   return WK_SCBR;
            OFS_CLSR:   return WK_CLSR;
            OFS_SCMR:   return WK_SCMR;
            default:    return WK_NONE;
        endcase
    endfunction

    wr_kind_t   kind;
    logic [9:0] off;
    logic [8:0] c_addr;
    logic       blocked;
    logic       go_nxt;
    logic [7:0] lo_latch;

    always_comb begin
        kind    = decode_wr(bus.CS, bus.reg_we_rising, bus.ADDR);
        off     = bus.ADDR[9:0];
        c_addr  = 9'(off - OFS_CACHE);
        blocked = go && (kind == WK_REG_LO || kind == WK_REG_HI || kind == WK_CACHE);
        // A go-setting write overrides a coincident core_stop.
        go_nxt  = go & ~core_stop;
        if (kind == WK_SFR)
            go_nxt = bus.DI[SFR_G_BIT];
        if (kind == WK_REG_HI && !blocked && off == OFS_R15H)
            go_nxt = 1'b1;
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            reg_we      <= '0;
            reg_idx     <= '0;
            reg_data    <= '0;
            go          <= '0;
            go_start    <= '0;
            pbr         <= '0;
            scbr        <= '0;
            cfgr        <= '0;
            scmr        <= '0;
            bramr       <= '0;
            clsr        <= '0;
            cache_we    <= '0;
            cache_addr  <= '0;
            cache_din   <= '0;
            cache_valid <= '0;
            lo_latch    <= '0;
        end else begin
            reg_we   <= 1'b0;
            cache_we <= 1'b0;
            go       <= go_nxt;
            go_start <= go_nxt & ~go;
            if (!blocked) begin
                case (kind)
                    WK_REG_LO: lo_latch <= bus.DI;
                    WK_REG_HI: begin
                        reg_we   <= 1'b1;
                        reg_idx  <= off[4:1];
                        reg_data <= {bus.DI, lo_latch};
                        if (off == OFS_R15H)
                            cache_valid <= '0;
                    end
                    WK_BRAMR:  bramr <= bus.DI[0];
                    WK_PBR:    pbr   <= bus.DI;
                    WK_CFGR:   cfgr  <= bus.DI;
                    WK_SCBR:   scbr  <= bus.DI;
                    WK_CLSR:   clsr  <= bus.DI[0];
                    WK_SCMR:   scmr  <= bus.DI[5:0];
                    WK_CACHE: begin
                        cache_we   <= 1'b1;
                        cache_addr <= c_addr;
                        cache_din  <= bus.DI;
                        if (c_addr[3:0] == 4'hF) begin
                            for (int unsigned i = 0; i < CACHE_LINES; i++)
                                if (i == 32'(c_addr[8:4]))
                                    cache_valid[i] <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
